// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Arbitrates between the instruction cache port and the data cache port for
// the single shared ram channel. A registered grant (IDLE / GNT_I / GNT_D)
// selects the owner. The grant is held until the ram reports ACCESS or ERROR,
// or until the owner drops its request. Ties are broken round-robin against
// the last port that completed.
//
// Optional feature: define MEM_ARB_WATCHDOG_EN to add a grant watchdog. When
// it is enabled, a grant that sees no ACCESS/ERROR for WD_LIMIT cycles is
// force-completed. The owner is released with load=0 and merr is pulsed.
//
// Ports:
//   CLK, nRST            clock, asynchronous active-low reset
//   iREN, iaddr          instruction read request / address
//   iwait, iload         instruction stall (0 = iload valid) / read data
//   dREN, dWEN           data read / write request (both high = write)
//   daddr, dstore        data address / write value
//   dwait, dload         data stall (0 = access completes) / read data
//   ramREN, ramWEN       ram read / write enable
//   ramaddr, ramstore    ram address / write data
//   ramload, ramstate    ram read data / status (FREE, BUSY, ACCESS, ERROR)
//   merr                 one-cycle pulse on ERROR completion or watchdog fire
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int WD_LIMIT = 255
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  output logic              iwait,
  output logic [DATA_W-1:0] iload,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dstore,
  output logic              dwait,
  output logic [DATA_W-1:0] dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [DATA_W-1:0] ramstore,
  input  logic [DATA_W-1:0] ramload,
  input  logic [1:0]        ramstate,
  output logic              merr
);

  typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} state_t;
  typedef enum logic {PORT_I, PORT_D} port_t;

  localparam logic [1:0] RAM_ACCESS = 2'd2;
  localparam logic [1:0] RAM_ERROR  = 2'd3;

  // A zero limit would fire the watchdog on the first grant cycle.
  if (WD_LIMIT < 1) begin : g_bad_wd_limit
    $error("mem_arbiter: WD_LIMIT must be at least 1");
  end

  state_t r_state;
  port_t  r_last;

  logic w_d_req;
  logic w_own_req;
  logic w_access;
  logic w_error;
  logic w_done_ok;
  logic w_wd_fire;
  logic w_release;

  assign w_d_req  = dREN | dWEN;
  assign w_access = (ramstate == RAM_ACCESS);
  assign w_error  = (ramstate == RAM_ERROR);

  // Only a requesting owner can complete. A dropped request is an abort.
  always_comb begin
    w_own_req = 1'b0;
    case (r_state)
      GNT_I:   w_own_req = iREN;
      GNT_D:   w_own_req = w_d_req;
      default: w_own_req = 1'b0;
    endcase
  end

  assign w_done_ok = w_own_req & (w_access | w_error);

`ifdef MEM_ARB_WATCHDOG_EN
  localparam int WD_W = $clog2(WD_LIMIT + 1);
  logic [WD_W-1:0] r_wd_cnt;

  assign w_wd_fire = w_own_req & ~(w_access | w_error) &
                     (r_wd_cnt == WD_W'(WD_LIMIT));

  // Every release (completion, abort, watchdog) changes state, so the
  // counter only keeps counting while the same grant keeps waiting.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_wd_cnt <= '0;
    end else if (w_own_req && !w_done_ok && !w_wd_fire) begin
      r_wd_cnt <= r_wd_cnt + WD_W'(1);
    end else begin
      r_wd_cnt <= '0;
    end
  end
`else
  assign w_wd_fire = 1'b0;
`endif

  assign w_release = w_done_ok | w_wd_fire;
  assign merr      = (w_own_req & w_error) | w_wd_fire;

  // Ram side and cache side outputs are combinational from the grant state
  // and the live port inputs. This makes an abort drop the enables in the
  // same cycle.
  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    iwait    = iREN;
    dwait    = w_d_req;
    iload    = '0;
    dload    = '0;
    case (r_state)
      GNT_I: begin
        ramREN  = iREN;
        ramaddr = iaddr;
        iwait   = iREN & ~w_release;
        iload   = (w_own_req & w_access) ? ramload : '0;
      end
      GNT_D: begin
        // A write takes precedence when both enables are high.
        ramREN   = dREN & ~dWEN;
        ramWEN   = dWEN;
        ramaddr  = daddr;
        ramstore = dstore;
        dwait    = w_d_req & ~w_release;
        dload    = (w_own_req & w_access) ? ramload : '0;
      end
      default: ;
    endcase
  end

  // Grant FSM.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state <= IDLE;
      r_last  <= PORT_I;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_d_req && iREN) begin
            r_state <= (r_last == PORT_I) ? GNT_D : GNT_I;
          end else if (w_d_req) begin
            r_state <= GNT_D;
          end else if (iREN) begin
            r_state <= GNT_I;
          end
        end
        GNT_I: begin
          if (!iREN) begin
            r_state <= IDLE;
          end else if (w_done_ok) begin
            r_last  <= PORT_I;
            r_state <= w_d_req ? GNT_D : IDLE;
          end else if (w_wd_fire) begin
            r_last  <= PORT_I;
            r_state <= IDLE;
          end
        end
        GNT_D: begin
          if (!w_d_req) begin
            r_state <= IDLE;
          end else if (w_done_ok) begin
            r_last  <= PORT_D;
            r_state <= iREN ? GNT_I : IDLE;
          end else if (w_wd_fire) begin
            r_last  <= PORT_D;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//
// Directed bench for mem_arbiter. The ram status is driven by hand, step by
// step. Each completion the bench causes pushes its expected port and load
// value onto a scoreboard queue. A monitor pops the queue whenever a
// requesting port sees wait=0.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

`ifdef MEM_ARB_WATCHDOG_EN
  localparam int WDL = 4;
`else
  localparam int WDL = 255;
`endif

  logic        CLK = 1'b0;
  logic        nRST;
  logic        iREN, dREN, dWEN;
  logic [31:0] iaddr, daddr, dstore, ramload;
  logic [1:0]  ramstate;
  logic        iwait, dwait, ramREN, ramWEN, merr;
  logic [31:0] iload, dload, ramaddr, ramstore;

  typedef struct packed {
    logic        port_d;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  int   compared   = 0;
  int   mismatched = 0;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .WD_LIMIT(WDL)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .merr(merr)
  );

  always #5 CLK = ~CLK;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic push(input logic port_d, input logic [31:0] data);
    exp_t e;
    e.port_d = port_d;
    e.data   = data;
    sb.push_back(e);
  endtask

  // Completion monitor: every cycle in which a requesting port is released
  // must match the next scoreboard entry.
  always @(negedge CLK) begin
    logic i_done, d_done;
    exp_t e;
    if (nRST === 1'b1) begin
      chk1("rd_wr_exclusive", ramREN & ramWEN, 1'b0);
      i_done = iREN & ~iwait;
      d_done = (dREN | dWEN) & ~dwait;
      if (i_done || d_done) begin
        if (sb.size() == 0) begin
          compared++;
          mismatched++;
          $error("FAIL sb_unexpected: observed completion i=%b d=%b required none", i_done, d_done);
        end else begin
          e = sb.pop_front();
          chk32("sb_port", {30'd0, d_done, i_done}, e.port_d ? 32'd2 : 32'd1);
          chk32("sb_load", d_done ? dload : iload, e.data);
        end
      end
    end
  end

  initial begin
    nRST = 1'b1; iREN = 1'b1; dREN = 1'b0; dWEN = 1'b0;
    iaddr = 32'h40; daddr = '0; dstore = '0; ramload = '0; ramstate = 2'd0;
    #1 nRST = 1'b0;

    // Reset holds everything quiet while iREN is asserted.
    @(negedge CLK);
    chk1("rst_ramREN", ramREN, 1'b0);
    chk1("rst_iwait", iwait, 1'b1);
    chk1("rst_merr", merr, 1'b0);
    chk32("rst_ramaddr", ramaddr, 32'h0);
    chk32("rst_iload", iload, 32'h0);

    // Single read: IDLE, BUSY, BUSY, ACCESS.
    tick(); nRST = 1'b1; ramstate = 2'd1;
    @(negedge CLK);
    chk1("rd_idle_ramREN", ramREN, 1'b0);
    chk1("rd_idle_iwait", iwait, 1'b1);
    tick();
    @(negedge CLK);
    chk1("rd_gnt_ramREN", ramREN, 1'b1);
    chk32("rd_gnt_ramaddr", ramaddr, 32'h40);
    chk1("rd_busy1_iwait", iwait, 1'b1);
    tick();
    @(negedge CLK);
    chk1("rd_busy2_iwait", iwait, 1'b1);
    tick(); ramstate = 2'd2; ramload = 32'h8C22_0000; push(1'b0, 32'h8C22_0000);
    @(negedge CLK);
    chk1("rd_access_iwait", iwait, 1'b0);
    tick(); iREN = 1'b0; ramstate = 2'd0;
    @(negedge CLK);
    chk1("rd_after_ramREN", ramREN, 1'b0);

    // Contention from reset: the data write wins, then the instruction read
    // follows with no idle cycle.
    tick(); nRST = 1'b0; iREN = 1'b1; iaddr = 32'h44;
    dWEN = 1'b1; daddr = 32'h100; dstore = 32'hDEAD_BEEF;
    tick(); nRST = 1'b1;
    @(negedge CLK);
    chk1("ct_idle_ramWEN", ramWEN, 1'b0);
    chk1("ct_idle_dwait", dwait, 1'b1);
    tick(); ramstate = 2'd2; ramload = 32'h1111_1111; push(1'b1, 32'h1111_1111);
    @(negedge CLK);
    chk1("ct_d_ramWEN", ramWEN, 1'b1);
    chk1("ct_d_ramREN", ramREN, 1'b0);
    chk32("ct_d_ramaddr", ramaddr, 32'h100);
    chk32("ct_d_ramstore", ramstore, 32'hDEAD_BEEF);
    chk1("ct_d_iwait", iwait, 1'b1);
    tick(); dWEN = 1'b0; ramload = 32'h2222_2222; push(1'b0, 32'h2222_2222);
    @(negedge CLK);
    chk1("ct_i_ramREN", ramREN, 1'b1);
    chk32("ct_i_ramaddr", ramaddr, 32'h44);
    chk32("ct_i_ramstore", ramstore, 32'h0);
    tick(); iREN = 1'b0; ramstate = 2'd0;
    @(negedge CLK);
    chk1("ct_end_ramREN", ramREN, 1'b0);

    // Fairness: both ports request continuously, and grants alternate D,I,...
    tick(); iREN = 1'b1; dREN = 1'b1; iaddr = 32'h300; daddr = 32'h200; ramstate = 2'd2;
    @(negedge CLK);
    chk1("fr_idle_dwait", dwait, 1'b1);
    for (int k = 0; k < 8; k++) begin
      tick();
      ramload = 32'hA000_0000 + 32'(k);
      push((k % 2) == 0, ramload);
      @(negedge CLK);
      chk32("fr_ramaddr", ramaddr, ((k % 2) == 0) ? 32'h200 : 32'h300);
    end
    tick(); iREN = 1'b0; dREN = 1'b0; ramstate = 2'd0;
    tick();
    @(negedge CLK);
    chk1("fr_end_ramREN", ramREN, 1'b0);

    // ERROR completes the data grant with load 0 and a single merr pulse.
    tick(); dREN = 1'b1; daddr = 32'h500; ramstate = 2'd1;
    tick(); ramstate = 2'd3; ramload = 32'hFFFF_FFFF; push(1'b1, 32'h0);
    @(negedge CLK);
    chk1("er_merr", merr, 1'b1);
    chk1("er_dwait", dwait, 1'b0);
    chk32("er_dload", dload, 32'h0);
    chk1("er_ramREN", ramREN, 1'b1);
    tick(); dREN = 1'b0; ramstate = 2'd0;
    @(negedge CLK);
    chk1("er_merr_off", merr, 1'b0);

    // Abort: dropping dREN mid-grant drops ramREN at once, and then IDLE.
    tick(); dREN = 1'b1; daddr = 32'h600; ramstate = 2'd1;
    tick();
    @(negedge CLK);
    chk1("ab_gnt_ramREN", ramREN, 1'b1);
    tick(); dREN = 1'b0;
    @(negedge CLK);
    chk1("ab_drop_ramREN", ramREN, 1'b0);
    chk1("ab_drop_merr", merr, 1'b0);
    tick(); iREN = 1'b1; iaddr = 32'h700;
    @(negedge CLK);
    chk1("ab_idle_ramREN", ramREN, 1'b0);
    chk1("ab_idle_iwait", iwait, 1'b1);
    tick(); ramstate = 2'd2; ramload = 32'h0000_700C; push(1'b0, 32'h0000_700C);
    @(negedge CLK);
    chk1("ab_next_ramREN", ramREN, 1'b1);
    tick(); iREN = 1'b0; ramstate = 2'd0;

    // Reset asserted mid-grant drops the enables without waiting for a clock.
    tick(); iREN = 1'b1; iaddr = 32'h800; ramstate = 2'd1;
    tick();
    @(negedge CLK);
    chk1("mr_gnt_ramREN", ramREN, 1'b1);
    #2 nRST = 1'b0;
    #1;
    chk1("mr_async_ramREN", ramREN, 1'b0);
    chk1("mr_async_iwait", iwait, 1'b1);
    tick(); nRST = 1'b1; iREN = 1'b0;

    // A grant held in BUSY.
    tick(); iREN = 1'b1; iaddr = 32'h900; ramstate = 2'd1;
`ifdef MEM_ARB_WATCHDOG_EN
    for (int c = 1; c <= 4; c++) begin
      tick();
      @(negedge CLK);
      chk1("wd_wait_merr", merr, 1'b0);
      chk1("wd_wait_iwait", iwait, 1'b1);
    end
    tick(); push(1'b0, 32'h0);
    @(negedge CLK);
    chk1("wd_fire_merr", merr, 1'b1);
    chk1("wd_fire_iwait", iwait, 1'b0);
    chk32("wd_fire_iload", iload, 32'h0);
    tick(); iREN = 1'b0;
    @(negedge CLK);
    chk1("wd_rel_ramREN", ramREN, 1'b0);
    chk1("wd_rel_merr", merr, 1'b0);
`else
    for (int c = 1; c <= 10; c++) begin
      tick();
      @(negedge CLK);
      chk1("nowd_merr", merr, 1'b0);
      chk1("nowd_iwait", iwait, 1'b1);
    end
    tick(); ramstate = 2'd2; ramload = 32'h0000_900D; push(1'b0, 32'h0000_900D);
    @(negedge CLK);
    chk1("nowd_done_iwait", iwait, 1'b0);
    tick(); iREN = 1'b0; ramstate = 2'd0;
`endif

    tick();
    @(negedge CLK);
    chk32("sb_drained", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
